// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: decodes {CMD,INDEX,DATA} SPI frames into strobes.
// Define SPI_DEC_WDOG_EN to add the comm watchdog (comm_timeout).
module spi_cmd_decoder #(
  parameter int N_CONTACTORS = 8,
`ifdef SPI_DEC_WDOG_EN
  parameter int WDOG_CYCLES = 1_000_000,
`endif
  localparam int IDX_W =
    (N_CONTACTORS > 1) ? $clog2(N_CONTACTORS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic                      frame_end,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic [7:0]                tx_byte,
  output logic                      tx_load,
  input  logic [2*N_CONTACTORS-1:0] contactor_state,
  input  logic [2*N_CONTACTORS-1:0] contactor_fb,
  input  logic                      feedback_timeout,
  input  logic [1:0]                thermal_shutdown,
  input  logic [7:0]                shutdown_status,
  output logic                      contactor_we,
  output logic [IDX_W-1:0]          contactor_idx,
  output logic [1:0]                contactor_val,
  output logic                      shutdown_we,
  output logic [7:0]                shutdown_cmd,
  output logic                      pg_shutdown_we,
  output logic                      pg_shutdown,
  output logic                      reset_req,
  output logic                      clear_errors,
  output logic                      invalid_request,
  output logic                      comm_timeout
);

  localparam logic [7:0] OP_RD_CONT = 8'h01;
  localparam logic [7:0] OP_RD_FB   = 8'h02;
  localparam logic [7:0] OP_RD_STAT = 8'h03;
  localparam logic [7:0] OP_RD_SHDN = 8'h04;
  localparam logic [7:0] OP_WR_CONT = 8'h81;
  localparam logic [7:0] OP_WR_CTRL = 8'h82;
  localparam logic [7:0] OP_WR_SHDN = 8'h83;
  localparam logic [7:0] OP_WR_PG   = 8'h84;
  localparam logic [8:0] N_LIM = 9'(N_CONTACTORS);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_IDX, S_DATA, S_DONE
  } state_t;

  typedef struct packed {
    logic       fb_timeout;
    logic       invalid;
    logic [1:0] thermal;
    logic [3:0] rsvd;
  } status_reg_t;

  typedef struct packed {
    logic [5:0] rsvd;
    logic [1:0] pm;
  } contactor_data_t;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             bad_q, bad_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_load_q, tx_load_d;
  logic             cwe_q, cwe_d;
  logic [IDX_W-1:0] cidx_q, cidx_d;
  logic [1:0]       cval_q, cval_d;
  logic             swe_q, swe_d;
  logic [7:0]       scmd_q, scmd_d;
  logic             pgwe_q, pgwe_d;
  logic             pg_q, pg_d;
  logic             rreq_q, rreq_d;
  logic             clr_q, clr_d;
  logic             inv_q, inv_d;

`ifdef SPI_DEC_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(WDOG_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  logic [IDX_W-1:0] rx_idx;
  logic             idx_ok;
  logic             op_known;
  logic             op_indexed;
  logic             commit;
  logic             set_err;
  logic [7:0]       resp;
  status_reg_t      status;
  contactor_data_t  cdata;

  assign rx_idx = rx_byte[IDX_W-1:0];
  assign idx_ok = {1'b0, rx_byte} < N_LIM;
  assign op_known = rx_byte inside {
    OP_RD_CONT, OP_RD_FB, OP_RD_STAT, OP_RD_SHDN,
    OP_WR_CONT, OP_WR_CTRL, OP_WR_SHDN, OP_WR_PG};
  assign op_indexed = op_q inside {
    OP_RD_CONT, OP_RD_FB, OP_WR_CONT};

  // Response is built from the index byte as it arrives.
  always_comb begin
    status = '{
      fb_timeout: feedback_timeout,
      invalid:    inv_q,
      thermal:    thermal_shutdown,
      rsvd:       4'h0};
    cdata = '0;
    resp  = 8'h00;
    case (op_q)
      OP_RD_CONT: begin
        cdata.pm = contactor_state[{rx_idx, 1'b0} +: 2];
        resp = idx_ok ? cdata : 8'hFF;
      end
      OP_RD_FB: begin
        cdata.pm = contactor_fb[{rx_idx, 1'b0} +: 2];
        resp = idx_ok ? cdata : 8'hFF;
      end
      OP_RD_STAT: resp = status;
      OP_RD_SHDN: resp = shutdown_status;
      default:    resp = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    data_d    = data_q;
    bad_d     = bad_q;
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    cwe_d     = 1'b0;
    cidx_d    = cidx_q;
    cval_d    = cval_q;
    swe_d     = 1'b0;
    scmd_d    = scmd_q;
    pgwe_d    = 1'b0;
    pg_d      = pg_q;
    rreq_d    = 1'b0;
    clr_d     = 1'b0;
    inv_d     = inv_q;
    commit    = 1'b0;
    set_err   = 1'b0;

    if (frame_end) begin
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        tx_byte_d = 8'h00;
        if (state_q == S_DONE && !bad_q) commit = 1'b1;
        else set_err = 1'b1;
      end
    end else if (frame_start) begin
      if (state_q != S_IDLE) set_err = 1'b1;
      state_d   = S_CMD;
      bad_d     = 1'b0;
      tx_byte_d = 8'h00;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: ;
        S_CMD: begin
          op_d    = rx_byte;
          state_d = S_IDX;
          if (!op_known) begin
            bad_d   = 1'b1;
            set_err = 1'b1;
          end
        end
        S_IDX: begin
          idx_d     = rx_idx;
          tx_byte_d = resp;
          tx_load_d = 1'b1;
          state_d   = S_DATA;
          if (op_indexed && !idx_ok) begin
            bad_d   = 1'b1;
            set_err = 1'b1;
          end
        end
        S_DATA: begin
          data_d  = rx_byte;
          state_d = S_DONE;
        end
        S_DONE: begin
          bad_d   = 1'b1;
          set_err = 1'b1;
        end
      endcase
    end

    if (commit) begin
      case (op_q)
        OP_WR_CONT: begin
          cwe_d  = 1'b1;
          cidx_d = idx_q;
          cval_d = data_q[1:0];
        end
        OP_WR_CTRL: begin
          rreq_d = data_q[0];
          clr_d  = data_q[1];
        end
        OP_WR_SHDN: begin
          swe_d  = 1'b1;
          scmd_d = data_q;
        end
        OP_WR_PG: begin
          pgwe_d = 1'b1;
          pg_d   = data_q[0];
        end
        default: ;
      endcase
    end

    // A new error outranks a simultaneous clear.
    if (set_err) inv_d = 1'b1;
    else if (commit && op_q == OP_WR_CTRL && data_q[1])
      inv_d = 1'b0;

`ifdef SPI_DEC_WDOG_EN
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (commit) begin
      cnt_d = CNT_RLD;
      tmo_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        tmo_d  = 1'b1;
        pgwe_d = 1'b1;
        pg_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 8'h00;
      idx_q     <= '0;
      data_q    <= 8'h00;
      bad_q     <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_load_q <= 1'b0;
      cwe_q     <= 1'b0;
      cidx_q    <= '0;
      cval_q    <= 2'b00;
      swe_q     <= 1'b0;
      scmd_q    <= 8'h00;
      pgwe_q    <= 1'b0;
      pg_q      <= 1'b0;
      rreq_q    <= 1'b0;
      clr_q     <= 1'b0;
      inv_q     <= 1'b0;
`ifdef SPI_DEC_WDOG_EN
      cnt_q     <= CNT_RLD;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      bad_q     <= bad_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      cwe_q     <= cwe_d;
      cidx_q    <= cidx_d;
      cval_q    <= cval_d;
      swe_q     <= swe_d;
      scmd_q    <= scmd_d;
      pgwe_q    <= pgwe_d;
      pg_q      <= pg_d;
      rreq_q    <= rreq_d;
      clr_q     <= clr_d;
      inv_q     <= inv_d;
`ifdef SPI_DEC_WDOG_EN
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign tx_byte         = tx_byte_q;
  assign tx_load         = tx_load_q;
  assign contactor_we    = cwe_q;
  assign contactor_idx   = cidx_q;
  assign contactor_val   = cval_q;
  assign shutdown_we     = swe_q;
  assign shutdown_cmd    = scmd_q;
  assign pg_shutdown_we  = pgwe_q;
  assign pg_shutdown     = pg_q;
  assign reset_req       = rreq_q;
  assign clear_errors    = clr_q;
  assign invalid_request = inv_q;
`ifdef SPI_DEC_WDOG_EN
  assign comm_timeout    = tmo_q;
`else
  assign comm_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: vector table, hand sequences and
// randomized frames against a frame-level reference model.
module tb_spi_cmd_decoder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_start = 1'b0;
  logic         frame_end = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic [7:0]   tx_byte;
  logic         tx_load;
  logic [2*N-1:0] cs = '0;
  logic [2*N-1:0] fb = '0;
  logic         ft = 1'b0;
  logic [1:0]   th = 2'b00;
  logic [7:0]   ss = 8'h00;
  logic         contactor_we;
  logic [2:0]   contactor_idx;
  logic [1:0]   contactor_val;
  logic         shutdown_we;
  logic [7:0]   shutdown_cmd;
  logic         pg_shutdown_we;
  logic         pg_shutdown;
  logic         reset_req;
  logic         clear_errors;
  logic         invalid_request;
  logic         comm_timeout;

  spi_cmd_decoder #(
    .N_CONTACTORS(N)
`ifdef SPI_DEC_WDOG_EN
    , .WDOG_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .tx_load(tx_load),
    .contactor_state(cs), .contactor_fb(fb),
    .feedback_timeout(ft), .thermal_shutdown(th),
    .shutdown_status(ss),
    .contactor_we(contactor_we),
    .contactor_idx(contactor_idx),
    .contactor_val(contactor_val),
    .shutdown_we(shutdown_we),
    .shutdown_cmd(shutdown_cmd),
    .pg_shutdown_we(pg_shutdown_we),
    .pg_shutdown(pg_shutdown),
    .reset_req(reset_req),
    .clear_errors(clear_errors),
    .invalid_request(invalid_request),
    .comm_timeout(comm_timeout)
  );

  always #5 clk = ~clk;

  wire [4:0] strb = {contactor_we, shutdown_we,
                     pg_shutdown_we, reset_req, clear_errors};
  wire [14:0] held = {invalid_request, contactor_idx,
                      contactor_val, shutdown_cmd, pg_shutdown};

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic       m_inv = 1'b0;
  logic [2:0] m_cidx = '0;
  logic [1:0] m_cval = '0;
  logic [7:0] m_scmd = '0;
  logic       m_pg = 1'b0;
  bit         m_open = 1'b0;

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [7:0]  tx;
    logic [4:0]  strb;
    logic        inv;
    logic [2:0]  cidx;
    logic [1:0]  cval;
    logic [7:0]  scmd;
    logic        pg;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    frame_end = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic do_frame(input logic [31:0] bytes,
                          input int n,
                          input bit no_end,
                          output int txcnt,
                          output logic [8:0] txat,
                          output logic [4:0] early,
                          output logic [4:0] s1,
                          output logic [4:0] s2,
                          output logic [7:0] txafter);
    txcnt = 0;
    txat = '0;
    early = '0;
    s1 = '0;
    s2 = '0;
    txafter = '0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    early |= strb;
    if (tx_load) txcnt++;
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_byte = bytes[31-8*i -: 8];
      tick();
      rx_valid = 1'b0;
      early |= strb;
      if (tx_load) txcnt++;
      if (i == 1) txat = {tx_load, tx_byte};
      tick();
      early |= strb;
      if (tx_load) txcnt++;
    end
    if (!no_end) begin
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      s1 = strb;
      txafter = tx_byte;
      if (tx_load) txcnt++;
      tick();
      s2 = strb;
    end
  endtask

  function automatic logic [7:0] exp_resp(input logic [7:0] op,
                                          input logic [7:0] idx);
    case (op)
      8'h01: return (int'(idx) < N) ?
                    8'((cs >> (2 * int'(idx))) & 3) : 8'hFF;
      8'h02: return (int'(idx) < N) ?
                    8'((fb >> (2 * int'(idx))) & 3) : 8'hFF;
      8'h03: return {ft, m_inv, th, 4'h0};
      8'h04: return ss;
      default: return 8'h00;
    endcase
  endfunction

  task automatic rnd_frame(input logic [31:0] bytes,
                           input int n, input bit no_end,
                           input string tag);
    logic [7:0] op, idx, dat;
    logic [7:0] etx;
    logic [4:0] es;
    bit known, need_idx, ok;
    int txcnt;
    logic [8:0] txat;
    logic [4:0] early, s1, s2;
    logic [7:0] txa;
    op  = bytes[31:24];
    idx = bytes[23:16];
    dat = bytes[15:8];
    if (m_open) m_inv = 1'b1;
    known = op inside {8'h01, 8'h02, 8'h03, 8'h04,
                       8'h81, 8'h82, 8'h83, 8'h84};
    need_idx = op inside {8'h01, 8'h02, 8'h81};
    ok = (n == 3) && known && (!need_idx || int'(idx) < N);
    etx = exp_resp(op, idx);
    do_frame(bytes, n, no_end, txcnt, txat, early, s1, s2, txa);
    check({tag, " txcnt"}, 64'(txcnt), (n >= 2) ? 1 : 0);
    if (n >= 2) check({tag, " tx"}, 64'(txat), {1'b1, etx});
    check({tag, " early"}, 64'(early), 0);
    if (no_end) begin
      m_open = 1'b1;
      return;
    end
    m_open = 1'b0;
    es = '0;
    if (ok) begin
      case (op)
        8'h81: begin
          es = 5'b10000;
          m_cidx = idx[2:0];
          m_cval = dat[1:0];
        end
        8'h82: es = {3'b000, dat[0], dat[1]};
        8'h83: begin
          es = 5'b01000;
          m_scmd = dat;
        end
        8'h84: begin
          es = 5'b00100;
          m_pg = dat[0];
        end
        default: ;
      endcase
    end
    if (!ok) m_inv = 1'b1;
    else if (op == 8'h82 && dat[1]) m_inv = 1'b0;
    check({tag, " strobe"}, 64'(s1), 64'(es));
    check({tag, " pulse"}, 64'(s2), 0);
    check({tag, " txidle"}, 64'(txa), 0);
    check({tag, " held"}, 64'(held),
          64'({m_inv, m_cidx, m_cval, m_scmd, m_pg}));
  endtask

  initial begin
    int txcnt;
    logic [8:0] txat;
    logic [4:0] early, s1, s2;
    logic [7:0] txa;
    logic [7:0] ops [8];
    string tg;

    tbl[0]  = '{32'h81030200, 3, 8'h00, 5'b10000, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[1]  = '{32'h02050000, 3, 8'h01, 5'b00000, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[2]  = '{32'h81030000, 2, 8'h00, 5'b00000, 1'b1,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[3]  = '{32'h03000000, 3, 8'h40, 5'b00000, 1'b1,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[4]  = '{32'h82000200, 3, 8'h00, 5'b00001, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[5]  = '{32'h82000100, 3, 8'h00, 5'b00010, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[6]  = '{32'h7F000000, 3, 8'h00, 5'b00000, 1'b1,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[7]  = '{32'h01080000, 3, 8'hFF, 5'b00000, 1'b1,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[8]  = '{32'h82000300, 3, 8'h00, 5'b00011, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[9]  = '{32'h01020000, 3, 8'h02, 5'b00000, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[10] = '{32'h04000000, 3, 8'h5A, 5'b00000, 1'b0,
                3'd3, 2'd2, 8'h00, 1'b0};
    tbl[11] = '{32'h83A5C300, 3, 8'h00, 5'b01000, 1'b0,
                3'd3, 2'd2, 8'hC3, 1'b0};
    tbl[12] = '{32'h84000100, 3, 8'h00, 5'b00100, 1'b0,
                3'd3, 2'd2, 8'hC3, 1'b1};
    tbl[13] = '{32'h81070100, 4, 8'h00, 5'b00000, 1'b1,
                3'd3, 2'd2, 8'hC3, 1'b1};
    tbl[14] = '{32'h82000200, 3, 8'h00, 5'b00001, 1'b0,
                3'd3, 2'd2, 8'hC3, 1'b1};
    tbl[15] = '{32'h00000000, 0, 8'h00, 5'b00000, 1'b1,
                3'd3, 2'd2, 8'hC3, 1'b1};
    tbl[16] = '{32'h81070100, 3, 8'h00, 5'b10000, 1'b1,
                3'd7, 2'd1, 8'hC3, 1'b1};
    tbl[17] = '{32'h84000000, 3, 8'h00, 5'b00100, 1'b1,
                3'd7, 2'd1, 8'hC3, 1'b0};

    ops = '{8'h01, 8'h02, 8'h03, 8'h04,
            8'h81, 8'h82, 8'h83, 8'h84};

    do_reset();
    check("reset", 64'({tx_byte, tx_load, strb, held, comm_timeout}), 0);

`ifdef SPI_DEC_WDOG_EN
    begin
      int fired = -1;
      int pulses = 0;
      logic pgl = 1'b0;
      for (int c = 0; c < 300; c++) begin
        tick();
        if (pg_shutdown_we) begin
          pulses++;
          pgl = pg_shutdown;
        end
        if (comm_timeout && fired < 0) fired = c;
      end
      check("wdog fire", 64'(fired >= 90 && fired <= 110), 1);
      check("wdog pulses", 64'(pulses), 1);
      check("wdog pg", 64'(pgl), 1);
      check("wdog level", 64'(comm_timeout), 1);
      do_frame(32'h03000000, 3, 0, txcnt, txat, early, s1, s2, txa);
      check("wdog clear", 64'(comm_timeout), 0);
      do_reset();
    end
`endif

    cs = 16'hE4E4;
    fb = 16'h0400;
    ss = 8'h5A;
    for (int i = 0; i < 18; i++) begin
`ifdef SPI_DEC_WDOG_EN
      do_frame(32'h03000000, 3, 0, txcnt, txat, early, s1, s2, txa);
`endif
      tg = $sformatf("vec%0d", i);
      do_frame(tbl[i].bytes, tbl[i].n, 0,
               txcnt, txat, early, s1, s2, txa);
      check({tg, " txcnt"}, 64'(txcnt), (tbl[i].n >= 2) ? 1 : 0);
      if (tbl[i].n >= 2)
        check({tg, " tx"}, 64'(txat), {1'b1, tbl[i].tx});
      check({tg, " early"}, 64'(early), 0);
      check({tg, " strobe"}, 64'(s1), 64'(tbl[i].strb));
      check({tg, " pulse"}, 64'(s2), 0);
      check({tg, " txidle"}, 64'(txa), 0);
      check({tg, " held"}, 64'(held),
            64'({tbl[i].inv, tbl[i].cidx, tbl[i].cval,
                 tbl[i].scmd, tbl[i].pg}));
    end

    m_inv = 1'b1; m_cidx = 3'd7; m_cval = 2'd1;
    m_scmd = 8'hC3; m_pg = 1'b0; m_open = 1'b0;

    // abort: second frame_start while a frame is open
    rnd_frame(32'h82000200, 3, 0, "abort clr");
    rnd_frame(32'h81010000, 2, 1, "abort open");
    rnd_frame(32'h02050000, 3, 0, "abort next");
    check("abort inv", 64'(invalid_request), 1);

    // reset in the middle of a write frame
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_byte = (i == 0) ? 8'h81 : 8'h02;
      tick();
      rx_valid = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("rstmid strobe", 64'(strb), 0);
    tick();
    check("rstmid held", 64'(held), 0);
    m_inv = 1'b0; m_cidx = '0; m_cval = '0;
    m_scmd = '0; m_pg = 1'b0; m_open = 1'b0;

    for (int k = 0; k < 150; k++) begin
      logic [7:0] op;
      int n, r;
      bit ne;
      cs = 16'($urandom);
      fb = 16'($urandom);
      ft = 1'($urandom);
      th = 2'($urandom);
      ss = 8'($urandom);
      r = $urandom_range(0, 9);
      op = (r < 8) ? ops[r] : 8'($urandom);
      r = $urandom_range(0, 9);
      n = (r < 7) ? 3 : (r == 7) ? 2 : (r == 8) ? 4 :
          $urandom_range(0, 1);
      ne = ($urandom_range(0, 11) == 0);
      if (!m_open && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b1;
        rx_byte = 8'h81;
        tick();
        rx_valid = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
`ifdef SPI_DEC_WDOG_EN
      rnd_frame(32'h03000000, 3, 0, $sformatf("keep%0d", k));
`endif
      rnd_frame({op, 8'($urandom_range(0, 11)),
                 8'($urandom), 8'($urandom)},
                n, ne, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
